// File: rtl/gat_bram_load_bridge.sv
// Host-to-accelerator BRAM loader: steers a byte-addressed write stream to N_CH channel BRAMs,
// tracks per-channel word counts for load_done, and serves a latency-matched feature readback.
module gat_bram_load_bridge #(
  parameter int TOP_WIDTH = 32,
  parameter int N_CH      = 3,
  parameter int CH_W      = 2,
  parameter int BRAM_AW   = 18,
  parameter int BRAM_DW   = 19,
  parameter int LEN_W     = 19,
  parameter int FEAT_AW   = 16,
  parameter int RD_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [N_CH*LEN_W-1:0]   cfg_len,
  input  logic                    s_en,
  input  logic                    s_we,
  input  logic [CH_W-1:0]         s_ch,
  input  logic [BRAM_AW+1:0]      s_addr,
  input  logic [TOP_WIDTH-1:0]    s_din,
  output logic                    s_ready,
  output logic [N_CH-1:0]         bram_we,
  output logic [BRAM_AW-1:0]      bram_addr,
  output logic [BRAM_DW-1:0]      bram_din,
  output logic [N_CH-1:0]         load_done,
  output logic                    all_done,
  output logic [2:0]              err_flags,
  input  logic                    rd_en,
  input  logic [FEAT_AW+1:0]      rd_addr,
  output logic [FEAT_AW-1:0]      feat_addrb,
  input  logic [TOP_WIDTH-1:0]    feat_dout,
  output logic                    rd_valid,
  output logic [TOP_WIDTH-1:0]    rd_data
);

  localparam int CW = (LEN_W > BRAM_AW) ? LEN_W : BRAM_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q [N_CH];
  logic [LEN_W-1:0]     len_d [N_CH];
  logic [LEN_W-1:0]     cnt_q [N_CH];
  logic [LEN_W-1:0]     cnt_d [N_CH];
  logic [N_CH-1:0]      done_q, done_d;
  logic [N_CH-1:0]      we_q, we_d;
  logic [BRAM_AW-1:0]   addr_q, addr_d;
  logic [BRAM_DW-1:0]   din_q, din_d;
  logic [2:0]           err_q, err_d;

  logic [LEN_W-1:0]     sel_len;
  logic [BRAM_AW-1:0]   waddr;
  logic                 wr_req, ch_ok, aligned, in_range, accept;

  always_comb begin
    sel_len = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (s_ch == CH_W'(c)) sel_len = len_q[c];
    end
  end

  // A load_start in the same cycle as a write wins: the write is dropped, not flagged.
  assign wr_req   = s_en & s_we & (state_q == ST_LOAD) & ~load_start;
  assign ch_ok    = (int'(s_ch) < N_CH);
  assign aligned  = (s_addr[1:0] == 2'b00);
  assign waddr    = s_addr[BRAM_AW+1:2];
  assign in_range = (CW'(waddr) < CW'(sel_len));
  assign accept   = wr_req & ch_ok & aligned & in_range;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = '0;
    addr_d  = addr_q;
    din_d   = din_q;

    case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: if (!load_start && (&done_q)) state_d = ST_DONE;
      ST_DONE: if (load_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase

    if (load_start) begin
      err_d = '0;
      for (int c = 0; c < N_CH; c++) begin
        len_d[c]  = cfg_len[c*LEN_W +: LEN_W];
        cnt_d[c]  = '0;
        done_d[c] = (cfg_len[c*LEN_W +: LEN_W] == '0);
      end
    end else if (accept) begin
      addr_d = waddr;
      din_d  = s_din[BRAM_DW-1:0];
      for (int c = 0; c < N_CH; c++) begin
        if (s_ch == CH_W'(c)) begin
          we_d[c] = 1'b1;
          if (cnt_q[c] != len_q[c]) cnt_d[c] = cnt_q[c] + LEN_W'(1);
          // done registers alongside the write pulse so both appear in the same cycle
          if (cnt_d[c] == len_q[c]) done_d[c] = 1'b1;
        end
      end
    end else if (wr_req) begin
      if (!ch_ok)        err_d[0] = 1'b1;
      else if (!aligned) err_d[2] = 1'b1;
      else               err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        len_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign all_done  = (state_q == ST_DONE);
  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign load_done = done_q;
  assign err_flags = err_q;

  // Readback: RD_LAT counts the feature BRAM's own delay plus the capture register here,
  // so feat_dout is sampled one stage before the token leaves the pipe.
  logic [RD_LAT-1:0]    vld_q;
  logic [RD_LAT:0]      tok;
  logic [TOP_WIDTH-1:0] rdat_q;

  assign tok        = {vld_q, rd_en};
  assign feat_addrb = rd_addr[FEAT_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      rdat_q <= '0;
    end else begin
      vld_q <= tok[RD_LAT-1:0];
      if (tok[RD_LAT-1]) rdat_q <= feat_dout;
    end
  end

  assign rd_valid = vld_q[RD_LAT-1];
  assign rd_data  = rdat_q;

  logic unused_bits;
  assign unused_bits = ^{s_din[TOP_WIDTH-1:BRAM_DW], rd_addr[1:0]};

endmodule
